// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the peripheral data bus with a slave-ack timeout watchdog.
// Define ARB_FIXED_PRIO_EN to make m0 win every tie (fixed priority) instead of round-robin.
module dbus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic                m0_w_en,
  input  logic [DATA_W/8-1:0] m0_sel,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_w_en,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                s_req,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic                s_w_en,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] C_SAT  = CNT_W'((TIMEOUT > 0) ? TIMEOUT : 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_s_req;
  logic [ADDR_W-1:0]   r_s_addr;
  logic [DATA_W-1:0]   r_s_wdata;
  logic                r_s_w_en;
  logic [DATA_W/8-1:0] r_s_sel;
  logic                r_m0_ack, r_m1_ack;
  logic                r_m0_err, r_m1_err;
  logic [DATA_W-1:0]   r_m0_rdata, r_m1_rdata;
  logic [1:0]          r_grant;

  logic w_elig0, w_elig1, w_pick1, w_expired;

  // A master whose ack is on the bus this cycle is still holding its old req.
  assign w_elig0 = m0_req & ~r_m0_ack;
  assign w_elig1 = m1_req & ~r_m1_ack;

`ifdef ARB_FIXED_PRIO_EN
  assign w_pick1 = w_elig1 & ~w_elig0;
`else
  logic r_last;  // 1: m1 was granted last
  assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);

  always_ff @(posedge clk) begin
    if (rst)
      r_last <= 1'b1;
    else if (r_state == IDLE && (w_elig0 | w_elig1))
      r_last <= w_pick1;
  end
`endif

  // Counter holds the number of completed BUSY cycles, so TIMEOUT-1 marks the last one.
  assign w_expired = (TIMEOUT != 0) && (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_s_req    <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_s_w_en   <= 1'b0;
      r_s_sel    <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_grant    <= '0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_elig0 | w_elig1) begin
            r_s_req <= 1'b1;
            r_cnt   <= '0;
            if (w_pick1) begin
              r_s_addr  <= m1_addr;
              r_s_wdata <= m1_wdata;
              r_s_w_en  <= m1_w_en;
              r_s_sel   <= m1_sel;
              r_grant   <= 2'b10;
              r_state   <= BUSY1;
            end else begin
              r_s_addr  <= m0_addr;
              r_s_wdata <= m0_wdata;
              r_s_w_en  <= m0_w_en;
              r_s_sel   <= m0_sel;
              r_grant   <= 2'b01;
              r_state   <= BUSY0;
            end
          end
        end
        BUSY0, BUSY1: begin
          if (s_ack || w_expired) begin
            r_s_req <= 1'b0;
            r_grant <= '0;
            r_state <= IDLE;
            if (r_state == BUSY1) begin
              r_m1_ack   <= 1'b1;
              r_m1_err   <= ~s_ack;
              r_m1_rdata <= (s_ack && !r_s_w_en) ? s_rdata : '0;
            end else begin
              r_m0_ack   <= 1'b1;
              r_m0_err   <= ~s_ack;
              r_m0_rdata <= (s_ack && !r_s_w_en) ? s_rdata : '0;
            end
          end else if (r_cnt != C_SAT) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_req    = r_s_req;
  assign s_addr   = r_s_addr;
  assign s_wdata  = r_s_wdata;
  assign s_w_en   = r_s_w_en;
  assign s_sel    = r_s_sel;
  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_err   = r_m0_err;
  assign m1_err   = r_m1_err;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;
  assign grant_o  = r_grant;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: bench-side slave model, per-master expected-response queues.
module tb_dbus_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_w_en, m1_w_en, m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic        s_req, s_w_en, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant_o;

  dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_w_en(m0_w_en), .m0_sel(m0_sel),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_w_en(m1_w_en), .m1_sel(m1_sel),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_w_en(s_w_en), .s_sel(s_sel),
    .s_ack(s_ack), .s_rdata(s_rdata), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        w_en;
    logic [3:0]  sel;
    int unsigned lat;   // s_req cycles before the slave acks; > TO means never
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int unsigned errors = 0;
  int unsigned checks = 0;
  rsp_t        q0[$];
  rsp_t        q1[$];
  logic        exp_grant[$];
  txn_t        tbl[logic [31:0]];
  bit          stray_en = 1'b0;
  bit          force_stray = 1'b0;
  int unsigned serial = 0;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic m, input logic w, input int unsigned lat);
    txn_t t;
    logic [31:0] s;
    serial++;
    s = serial;
    t.m     = m;
    t.addr  = {m, s[14:0], 16'($urandom)};
    t.wdata = $urandom;
    t.w_en  = w;
    t.sel   = 4'($urandom);
    t.lat   = lat;
    return t;
  endfunction

  task automatic drive(input txn_t t);
    if (t.m) begin
      m1_addr = t.addr; m1_wdata = t.wdata; m1_w_en = t.w_en; m1_sel = t.sel; m1_req = 1'b1;
    end else begin
      m0_addr = t.addr; m0_wdata = t.wdata; m0_w_en = t.w_en; m0_sel = t.sel; m0_req = 1'b1;
    end
  endtask

  // Called at posedge+1; returns in the ack cycle.
  task automatic issue(input txn_t t, input bit drop, input bit chk_lat);
    rsp_t e;
    int unsigned n;
    bit got;
    e.err   = (t.lat > TO);
    e.rdata = (e.err || t.w_en) ? 32'h0 : slave_data(t.addr);
    tbl[t.addr] = t;
    if (t.m) q1.push_back(e); else q0.push_back(e);
    drive(t);
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      got = t.m ? m1_ack : m0_ack;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_wait m%0d: no ack after %0d cycles, required within 100", t.m, n);
    end else if (chk_lat) begin
      check("ack_latency", n, e.err ? TO + 1 : t.lat + 1);
    end
    if (drop) begin
      if (t.m) m1_req = 1'b0; else m0_req = 1'b0;
    end
  endtask

  task automatic mon(input int m, input logic [31:0] rd, input logic er);
    rsp_t e;
    bit empty;
    empty = (m == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      checks++; errors++;
      $display("FAIL unexpected_ack m%0d: got ack, expected none", m);
    end else begin
      if (m == 0) e = q0.pop_front(); else e = q1.pop_front();
      check($sformatf("rdata_m%0d", m), rd, e.rdata);
      check($sformatf("err_m%0d", m), er, e.err);
    end
    check("ack_cycle_sreq", s_req, 0);
    check("ack_cycle_grant", grant_o, 0);
  endtask

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (m0_ack) mon(0, m0_rdata, m0_err);
      if (m1_ack) mon(1, m1_rdata, m1_err);
      check("err_without_ack", {m1_err & ~m1_ack, m0_err & ~m0_ack}, 0);
    end
  end

  // Slave model: acks after the transaction's latency, also checks forwarded fields and owner
  initial begin
    int unsigned cnt;
    txn_t cur;
    bit have;
    logic g;
    cnt = 0; have = 1'b0;
    s_ack = 1'b0; s_rdata = '0;
    forever begin
      @(negedge clk);
      if (s_req) begin
        cnt++;
        if (cnt == 1) begin
          have = tbl.exists(s_addr);
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL slave_addr: got 0x%h, expected an issued address", s_addr);
          end else begin
            cur = tbl[s_addr];
            if (exp_grant.size() > 0) begin
              g = exp_grant.pop_front();
              check("grant_order", cur.m, g);
            end
          end
        end
        if (have) begin
          check("s_addr", s_addr, cur.addr);
          check("s_wdata", s_wdata, cur.wdata);
          check("s_w_en", s_w_en, cur.w_en);
          check("s_sel", s_sel, cur.sel);
          check("busy_grant", grant_o, cur.m ? 2'b10 : 2'b01);
        end
        s_ack   = have && (cnt == cur.lat);
        s_rdata = s_ack ? slave_data(s_addr) : $urandom;
      end else begin
        cnt  = 0;
        have = 1'b0;
        check("idle_grant", grant_o, 0);
        s_ack   = force_stray || (stray_en && ($urandom_range(0, 2) == 0));
        s_rdata = $urandom;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    txn_t a, b, c;
    rst = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1;
    m0_addr = '0; m0_wdata = '0; m0_w_en = 1'b0; m0_sel = '0;
    m1_addr = '0; m1_wdata = '0; m1_w_en = 1'b0; m1_sel = '0;

    // Reset with both masters requesting: nothing may start
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_req", s_req, 0);
    check("rst_grant", grant_o, 0);
    check("rst_acks", {m1_ack, m0_ack}, 0);
    check("rst_errs", {m1_err, m0_err}, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_wdata", s_wdata, 0);
    check("rst_s_ctl", {s_w_en, s_sel}, 0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    stray_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Single read, slave acks on the third s_req cycle
    a = mk(0, 0, 3);
    a.addr = 32'h0000_0010;
    a.sel = 4'hF;
    issue(a, 1, 1);
    repeat (2) begin @(posedge clk); #1; end

    // m1 write that the slave never acks
    a = mk(1, 1, TO + 1);
    issue(a, 1, 1);
    repeat (2) begin @(posedge clk); #1; end

    // Ack in the expiry cycle wins over the timeout
    a = mk(0, 0, TO);
    issue(a, 1, 1);

    // Guaranteed stray acks while idle
    force_stray = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stray_s_req", s_req, 0);
    end
    force_stray = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of an m0 transaction
    a = mk(0, 0, 30);
    tbl[a.addr] = a;
    exp_grant.push_back(1'b0);
    drive(a);
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_s_req", s_req, 1);
    rst = 1'b1;
    m0_req = 1'b0;
    @(posedge clk); #1;
    check("midrst_s_req", s_req, 0);
    check("midrst_grant", grant_o, 0);
    check("midrst_m0_ack", m0_ack, 0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Tie after reset goes to m0; after an m0-only grant the next tie goes to m1
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    a = mk(0, 0, 2);
    b = mk(1, 0, 1);
    fork
      issue(a, 1, 0);
      issue(b, 1, 0);
    join
    repeat (2) begin @(posedge clk); #1; end
    exp_grant.push_back(1'b0);
    c = mk(0, 1, 1);
    issue(c, 1, 0);
    repeat (2) begin @(posedge clk); #1; end
    exp_grant.push_back(1'b1);
    exp_grant.push_back(1'b0);
    a = mk(0, 0, 4);
    b = mk(1, 1, 2);
    fork
      issue(a, 1, 0);
      issue(b, 1, 0);
    join
    repeat (2) begin @(posedge clk); #1; end

    // Randomized traffic from both masters
    fork
      begin
        txn_t t;
        int unsigned gap;
        for (int unsigned i = 0; i < 40; i++) begin
          t = mk(0, 1'($urandom), $urandom_range(1, 10));
          gap = (i == 39) ? 1 : $urandom_range(0, 2);
          issue(t, gap != 0, 0);
          repeat (gap) begin @(posedge clk); #1; end
        end
      end
      begin
        txn_t t;
        int unsigned gap;
        for (int unsigned i = 0; i < 40; i++) begin
          t = mk(1, 1'($urandom), $urandom_range(1, 10));
          gap = (i == 39) ? 1 : $urandom_range(0, 2);
          issue(t, gap != 0, 0);
          repeat (gap) begin @(posedge clk); #1; end
        end
      end
    join
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("grant_order_drained", exp_grant.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
